dma_apb_slave: RTL and testbench



---
 rtl/dma_apb_slave.sv | 237 +++++++++++++++++++++++
 tb/tb_dma_apb_slave.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_apb_slave.sv
// dma_apb_slave: APB register file exposing the DMA engine programming registers.
// Wait-stated ACCESS phase; CMD writes become a one-cycle start pulse, completion latches into STATUS.DONE.
module dma_apb_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned PSTRB_WIDTH = 4,
    parameter int unsigned PPROT_WIDTH = 3,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned LEN_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_apb_psel,
    input  logic                   s_apb_penable,
    input  logic                   s_apb_pwrite,
    input  logic [ADDR_WIDTH-1:0]  s_apb_paddr,
    input  logic [DATA_WIDTH-1:0]  s_apb_pwdata,
    input  logic [PSTRB_WIDTH-1:0] s_apb_pstrb,
    input  logic [PPROT_WIDTH-1:0] s_apb_pprot,
    output logic [DATA_WIDTH-1:0]  s_apb_prdata,
    output logic                   s_apb_pready,
    output logic                   s_apb_pslverr,
    output logic [DATA_WIDTH-1:0]  dma_src,
    output logic [DATA_WIDTH-1:0]  dma_dst,
    output logic [LEN_WIDTH-1:0]   dma_len,
    output logic                   dma_start,
    input  logic                   dma_busy,
    input  logic                   dma_done
);

    localparam logic [7:0] OFF_SRC    = 8'h00;
    localparam logic [7:0] OFF_DST    = 8'h04;
    localparam logic [7:0] OFF_LEN    = 8'h08;
    localparam logic [7:0] OFF_CMD    = 8'h0C;
    localparam logic [7:0] OFF_STATUS = 8'h10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        SEL_SRC    = 3'd0,
        SEL_DST    = 3'd1,
        SEL_LEN    = 3'd2,
        SEL_CMD    = 3'd3,
        SEL_STATUS = 3'd4,
        SEL_NONE   = 3'd5
    } sel_t;

    function automatic logic [DATA_WIDTH-1:0] apply_strb(
        input logic [DATA_WIDTH-1:0]  old_v,
        input logic [DATA_WIDTH-1:0]  new_v,
        input logic [PSTRB_WIDTH-1:0] strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < PSTRB_WIDTH; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    sel_t                    sel_q, sel_d;
    logic                    err_q, err_d;
    logic                    wr_q, wr_d;
    logic                    go_q, go_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0]   src_q, src_d;
    logic [DATA_WIDTH-1:0]   dst_q, dst_d;
    logic [LEN_WIDTH-1:0]    len_q, len_d;
    logic                    done_q, done_d;
    logic                    start_q, start_d;

    sel_t                    dec_sel_s;
    logic                    cmd_req_s;
    logic                    dec_err_s;
    logic [DATA_WIDTH-1:0]   rd_val_s;
    logic                    commit_s;
    logic                    wr_commit_s;
    logic                    status_clr_s;
    logic                    pready_s;
    logic                    unused_s;

    assign unused_s = ^{s_apb_pprot, s_apb_paddr[ADDR_WIDTH-1:8]};

    // Decode the bus address presented in SETUP and form the read snapshot.
    always_comb begin
        dec_sel_s = SEL_NONE;
        case (s_apb_paddr[7:0])
            OFF_SRC:    dec_sel_s = SEL_SRC;
            OFF_DST:    dec_sel_s = SEL_DST;
            OFF_LEN:    dec_sel_s = SEL_LEN;
            OFF_CMD:    dec_sel_s = SEL_CMD;
            OFF_STATUS: dec_sel_s = SEL_STATUS;
            default:    dec_sel_s = SEL_NONE;
        endcase
        cmd_req_s = s_apb_pwrite && (dec_sel_s == SEL_CMD) && s_apb_pwdata[0] && s_apb_pstrb[0];
        dec_err_s = (dec_sel_s == SEL_NONE) || (cmd_req_s && dma_busy);
        rd_val_s  = '0;
        if (dec_err_s) begin
            rd_val_s = '0;
        end else begin
            case (dec_sel_s)
                SEL_SRC:    rd_val_s = src_q;
                SEL_DST:    rd_val_s = dst_q;
                SEL_LEN:    rd_val_s[LEN_WIDTH-1:0] = len_q;
                SEL_STATUS: rd_val_s[1:0] = {dma_busy, done_q};
                default:    rd_val_s = '0;
            endcase
        end
    end

    // Transfer FSM: capture decode at SETUP, count wait states, commit on the ready cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        err_d    = err_q;
        wr_d     = wr_q;
        go_d     = go_q;
        prdata_d = prdata_q;
        commit_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_apb_psel && !s_apb_penable) begin
                    state_d  = ST_ACCESS;
                    cnt_d    = 4'(WAIT_CYCLES);
                    sel_d    = dec_sel_s;
                    err_d    = dec_err_s;
                    wr_d     = s_apb_pwrite;
                    go_d     = cmd_req_s && !dma_busy;
                    prdata_d = rd_val_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!s_apb_psel) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (s_apb_penable) begin
                    commit_s = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pready_s      = (state_q == ST_ACCESS) && (cnt_q == 4'd0);
    assign s_apb_pready  = pready_s;
    assign s_apb_pslverr = pready_s && err_q;
    assign s_apb_prdata  = pready_s ? prdata_q : '0;

    assign wr_commit_s  = commit_s && wr_q && !err_q;
    // Write data and strobes are held by the master through ACCESS, so they are taken at the commit edge.
    assign status_clr_s = wr_commit_s && (sel_q == SEL_STATUS) && s_apb_pwdata[0] && s_apb_pstrb[0];

    // Register-file next state: strobed writes, start pulse and sticky DONE (set beats clear).
    always_comb begin
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        start_d = 1'b0;
        if (wr_commit_s) begin
            case (sel_q)
                SEL_SRC: src_d = apply_strb(src_q, s_apb_pwdata, s_apb_pstrb);
                SEL_DST: dst_d = apply_strb(dst_q, s_apb_pwdata, s_apb_pstrb);
                SEL_LEN: begin
                    for (int i = 0; i < LEN_WIDTH / 8; i++) begin
                        if (s_apb_pstrb[i]) begin
                            len_d[8*i +: 8] = s_apb_pwdata[8*i +: 8];
                        end
                    end
                end
                SEL_CMD: start_d = go_q;
                default: start_d = 1'b0;
            endcase
        end else begin
            start_d = 1'b0;
        end
        if (dma_done) begin
            done_d = 1'b1;
        end else if (start_d || status_clr_s) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    // State and register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            sel_q    <= SEL_NONE;
            err_q    <= 1'b0;
            wr_q     <= 1'b0;
            go_q     <= 1'b0;
            prdata_q <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            err_q    <= err_d;
            wr_q     <= wr_d;
            go_q     <= go_d;
            prdata_q <= prdata_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            len_q    <= len_d;
            done_q   <= done_d;
            start_q  <= start_d;
        end
    end

    assign dma_src   = src_q;
    assign dma_dst   = dst_q;
    assign dma_len   = len_q;
    assign dma_start = start_q;

endmodule

// File: tb/tb_dma_apb_slave.sv
// Bench for dma_apb_slave: two instances (1 and 3 wait states) checked every cycle against a
// transaction-level register model, plus literal expectations for the directed scenarios.
module tb_dma_apb_slave;

    localparam int W0 = 1;
    localparam int W1 = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        dma_busy, dma_done;

    logic [31:0] prdata_w [2];
    logic        pready_w [2];
    logic        pslverr_w [2];
    logic        start_w [2];
    logic [31:0] src_w [2];
    logic [31:0] dst_w [2];
    logic [15:0] len_w [2];

    logic [31:0] m_src [2];
    logic [31:0] m_dst [2];
    logic [15:0] m_len [2];
    logic        m_done [2];
    logic        clr [2];
    logic        e_pready [2];
    logic        e_slverr [2];
    logic        e_start [2];
    logic        e_prd_chk [2];
    logic [31:0] e_prdata [2];

    bit chk_en;
    bit rnd_done;
    int tests;
    int fails;

    always #5 clk = ~clk;

    dma_apb_slave #(.WAIT_CYCLES(W0)) u_dut0 (
        .clk(clk), .reset(reset),
        .s_apb_psel(psel[0]), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
        .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pprot(pprot),
        .s_apb_prdata(prdata_w[0]), .s_apb_pready(pready_w[0]), .s_apb_pslverr(pslverr_w[0]),
        .dma_src(src_w[0]), .dma_dst(dst_w[0]), .dma_len(len_w[0]), .dma_start(start_w[0]),
        .dma_busy(dma_busy), .dma_done(dma_done)
    );

    dma_apb_slave #(.WAIT_CYCLES(W1)) u_dut1 (
        .clk(clk), .reset(reset),
        .s_apb_psel(psel[1]), .s_apb_penable(penable), .s_apb_pwrite(pwrite),
        .s_apb_paddr(paddr), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pprot(pprot),
        .s_apb_prdata(prdata_w[1]), .s_apb_pready(pready_w[1]), .s_apb_pslverr(pslverr_w[1]),
        .dma_src(src_w[1]), .dma_dst(dst_w[1]), .dma_len(len_w[1]), .dma_start(start_w[1]),
        .dma_busy(dma_busy), .dma_done(dma_done)
    );

    task automatic cmp(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d: got %h want %h at %0t", name, d, act, exp, $time);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 1) ? W1 : W0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mread(input int d, input logic [7:0] off);
        case (off)
            8'h00:   return m_src[d];
            8'h04:   return m_dst[d];
            8'h08:   return {16'h0, m_len[d]};
            8'h10:   return {30'h0, dma_busy, m_done[d]};
            default: return 32'h0;
        endcase
    endfunction

    // Every cycle: all DUT outputs against the model expectations.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                cmp("pready", d, {31'h0, pready_w[d]}, {31'h0, e_pready[d]});
                cmp("pslverr", d, {31'h0, pslverr_w[d]}, {31'h0, e_slverr[d]});
                if (e_prd_chk[d]) cmp("prdata", d, prdata_w[d], e_prdata[d]);
                cmp("dma_start", d, {31'h0, start_w[d]}, {31'h0, e_start[d]});
                cmp("dma_src", d, src_w[d], m_src[d]);
                cmp("dma_dst", d, dst_w[d], m_dst[d]);
                cmp("dma_len", d, {16'h0, len_w[d]}, {16'h0, m_len[d]});
            end
        end
    end

    // One clock edge: advance the DONE model and reset, then let the driver set the next cycle.
    task automatic step();
        logic dn [2];
        logic rst_now;
        for (int d = 0; d < 2; d++) dn[d] = dma_done ? 1'b1 : (clr[d] ? 1'b0 : m_done[d]);
        rst_now = reset;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst_now) begin
                m_src[d] = 32'h0; m_dst[d] = 32'h0; m_len[d] = 16'h0; m_done[d] = 1'b0;
            end else begin
                m_done[d] = dn[d];
            end
            clr[d]     = 1'b0;
            e_start[d] = 1'b0;
        end
        #1;
        dma_done = rnd_done ? ($urandom_range(0, 7) == 0) : 1'b0;
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input bit done_at_commit,
                        output logic [31:0] rd, output logic err_o, output int rdy_at);
        logic [7:0]  off;
        logic [31:0] rv;
        logic [31:0] tmp;
        bit legal, go, err, last;
        off   = addr[7:0];
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
        legal = (off == 8'h00) || (off == 8'h04) || (off == 8'h08) || (off == 8'h0C) || (off == 8'h10);
        go    = legal && wr && (off == 8'h0C) && wdata[0] && strb[0];
        err   = !legal || (go && dma_busy);
        rv    = err ? 32'h0 : mread(d, off);
        rd = 32'h0; err_o = 1'b0; rdy_at = -1;
        step();
        penable = 1'b1;
        for (int i = 0; i <= wait_of(d); i++) begin
            last         = (i == wait_of(d));
            e_pready[d]  = last;
            e_slverr[d]  = last && err;
            e_prdata[d]  = (last && !wr) ? rv : 32'h0;
            e_prd_chk[d] = !(last && wr);
            if (last && wr && !err) begin
                clr[d] = ((off == 8'h0C) && go) || ((off == 8'h10) && wdata[0] && strb[0]);
                if (done_at_commit) dma_done = 1'b1;
            end
            @(negedge clk);
            if (pready_w[d] && rdy_at < 0) rdy_at = i;
            if (last) begin
                rd = prdata_w[d]; err_o = pslverr_w[d];
            end
            step();
        end
        psel[d] = 1'b0; penable = 1'b0;
        e_pready[d] = 1'b0; e_slverr[d] = 1'b0; e_prdata[d] = 32'h0; e_prd_chk[d] = 1'b1;
        if (wr && !err) begin
            case (off)
                8'h00: m_src[d] = merge(m_src[d], wdata, strb);
                8'h04: m_dst[d] = merge(m_dst[d], wdata, strb);
                8'h08: begin
                    tmp = merge({16'h0, m_len[d]}, wdata, strb);
                    m_len[d] = tmp[15:0];
                end
                8'h0C: e_start[d] = go;
                default: ;
            endcase
        end
    endtask

    logic [31:0] rd;
    logic        er;
    int          ra;
    logic [7:0]  offs [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h02, 8'hFC};

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int d;
        tests = 0; fails = 0; chk_en = 1'b0; rnd_done = 1'b0;
        reset = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        pstrb = 4'h0; pprot = 3'h0; dma_busy = 1'b0; dma_done = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_src[k] = 32'h0; m_dst[k] = 32'h0; m_len[k] = 16'h0; m_done[k] = 1'b0; clr[k] = 1'b0;
            e_pready[k] = 1'b0; e_slverr[k] = 1'b0; e_start[k] = 1'b0; e_prd_chk[k] = 1'b1;
            e_prdata[k] = 32'h0;
        end
        @(negedge clk);
        step(); step();
        reset = 1'b0;
        chk_en = 1'b1;

        xfer(0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("reset_read_src", 0, rd, 32'h0000_0000);

        xfer(0, 1'b1, 32'h00, 32'h1000_0000, 4'hF, 1'b0, rd, er, ra);
        cmp("pready_at_A0plus1", 0, ra, 32'd1);
        cmp("src_visible", 0, src_w[0], 32'h1000_0000);
        xfer(0, 1'b1, 32'h04, 32'h2000_0000, 4'hF, 1'b0, rd, er, ra);
        cmp("dst_visible", 0, dst_w[0], 32'h2000_0000);
        xfer(0, 1'b1, 32'h08, 32'hABCD_0040, 4'hF, 1'b0, rd, er, ra);
        cmp("len_visible", 0, {16'h0, len_w[0]}, 32'h0000_0040);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("read_src", 0, rd, 32'h1000_0000);
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("read_dst", 0, rd, 32'h2000_0000);
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("read_len_upper0", 0, rd, 32'h0000_0040);

        xfer(0, 1'b1, 32'h00, 32'hAABB_CCDD, 4'hF, 1'b0, rd, er, ra);
        xfer(0, 1'b1, 32'h00, 32'h1122_3344, 4'b0101, 1'b0, rd, er, ra);
        xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("byte_strobe", 0, rd, 32'hAA22_CC44);

        xfer(0, 1'b1, 32'h0C, 32'h1, 4'h1, 1'b0, rd, er, ra);
        cmp("start_pulse_hi", 0, {31'h0, start_w[0]}, 32'h1);
        step();
        cmp("start_pulse_lo", 0, {31'h0, start_w[0]}, 32'h0);
        dma_done = 1'b1;
        step();
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("status_done", 0, rd, 32'h1);
        xfer(0, 1'b1, 32'h10, 32'h1, 4'h1, 1'b0, rd, er, ra);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("status_w1c", 0, rd, 32'h0);
        xfer(0, 1'b1, 32'h10, 32'h1, 4'h1, 1'b1, rd, er, ra);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("status_set_wins", 0, rd, 32'h1);

        xfer(0, 1'b0, 32'h14, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("bad_off_slverr", 0, {31'h0, er}, 32'h1);
        cmp("bad_off_prdata", 0, rd, 32'h0);
        xfer(0, 1'b1, 32'h02, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er, ra);
        cmp("misalign_slverr", 0, {31'h0, er}, 32'h1);
        cmp("misalign_nochange", 0, src_w[0], 32'hAA22_CC44);
        dma_busy = 1'b1;
        xfer(0, 1'b1, 32'h0C, 32'h1, 4'hF, 1'b0, rd, er, ra);
        cmp("busy_cmd_slverr", 0, {31'h0, er}, 32'h1);
        cmp("busy_cmd_nostart", 0, {31'h0, start_w[0]}, 32'h0);
        xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("status_busy_done", 0, rd, 32'h3);
        dma_busy = 1'b0;
        xfer(0, 1'b1, 32'h0C, 32'h0, 4'hF, 1'b0, rd, er, ra);
        cmp("cmd_noop_noerr", 0, {31'h0, er}, 32'h0);

        xfer(1, 1'b1, 32'h00, 32'h5555_0000, 4'hF, 1'b0, rd, er, ra);
        cmp("pready_at_A0plus3", 1, ra, 32'd3);
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h1234_5678; pstrb = 4'hF;
        step();
        penable = 1'b1;
        step();
        psel[1] = 1'b0; penable = 1'b0;
        step(); step();
        cmp("abort_nochange", 1, src_w[1], 32'h5555_0000);
        psel[1] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        step();
        penable = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0; psel[1] = 1'b0; penable = 1'b0;
        step();
        cmp("reset_mid_dst", 1, dst_w[1], 32'h0);
        xfer(1, 1'b1, 32'h04, 32'hCAFE_F00D, 4'hF, 1'b0, rd, er, ra);
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 1'b0, rd, er, ra);
        cmp("after_reset_xfer", 1, rd, 32'hCAFE_F00D);

        rnd_done = 1'b1;
        for (int n = 0; n < 300; n++) begin
            d = $urandom_range(0, 1);
            r = $urandom();
            dma_busy = ($urandom_range(0, 3) == 0);
            xfer(d, 1'($urandom_range(0, 1)), {r[31:8], offs[$urandom_range(0, 7)]}, $urandom(),
                 4'($urandom_range(0, 15)), 1'b0, rd, er, ra);
            if ($urandom_range(0, 3) == 0) step();
        end
        rnd_done = 1'b0;
        step(); step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
